hack_ram_dp: RTL and testbench

- Parametrised successor to the single-port Hack data RAM: WIDTH x 2**ADDR_W words.
- Port A is read/write for the CPU data bus. Port B is a read-only second channel for the screen/IO refresh logic.
- An optional hardware clear engine zeroes the whole array after reset and reports `busy` while doing so.
- Sits between the Hack CPU memory interface and the memory-map decoder.

---
 rtl/hack_mem_pkg.sv | 15 +
 rtl/hack_ram_dp_if.sv | 30 +++
 rtl/hack_ram_clear_fsm.sv | 55 +++++
 rtl/hack_ram_dp.sv | 81 ++++++++
 tb/tb_hack_ram_dp.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/hack_mem_pkg.sv
// Shared types and default sizes for the Hack data RAM family.
//   HACK_WORD_W      default data word width
//   HACK_RAM_ADDR_W  default address width (depth = 2**HACK_RAM_ADDR_W)
//   clear_state_t    clear engine states
package hack_mem_pkg;

  localparam int HACK_WORD_W     = 16;
  localparam int HACK_RAM_ADDR_W = 14;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } clear_state_t;

endpackage

// File: rtl/hack_ram_dp_if.sv
// Bus bundle between the Hack CPU / refresh logic and the dual-port data RAM.
//   load, in, addr : port A write enable, write data, address (read/write)
//   out            : port A read data
//   addr_b, out_b  : port B read-only address and data
//   busy           : clear engine running
// master = CPU/refresh side, slave = RAM side.
interface hack_ram_dp_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 14
);

  logic              load;
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  out;
  logic [ADDR_W-1:0] addr_b;
  logic [WIDTH-1:0]  out_b;
  logic              busy;

  modport master (
    output load, in, addr, addr_b,
    input  out, out_b, busy
  );

  modport slave (
    input  load, in, addr, addr_b,
    output out, out_b, busy
  );

endinterface

// File: rtl/hack_ram_clear_fsm.sv
// Clear engine: after reset (when CLEAR_ON_RESET != 0) walks every address
// once, requesting a zero write per cycle, then drops to idle.
//   clock_i, reset_i : clock, synchronous active-high reset
//   busy_o           : sweep in progress
//   clr_we_o         : write-zero request for clr_addr_o this cycle
//   clr_addr_o       : address being cleared
module hack_ram_clear_fsm
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W         = HACK_RAM_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;
  localparam clear_state_t      RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic              RST_BUSY  = (CLEAR_ON_RESET != 0);

  clear_state_t      state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busy_q  <= RST_BUSY;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // Counter wraps back to 0 on the final address, ready for the next sweep.
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/hack_ram_dp.sv
// Dual-port Hack data RAM, WIDTH x 2**ADDR_W.
//   clock, reset : clock, synchronous active-high reset
//   bus          : port A read/write, port B read-only, busy (slave modport)
// Both read ports register the address and read the array combinationally
// from the registered address, which gives 1-cycle latency and write-first
// behaviour on both ports. Reads are forced to zero while clearing.
module hack_ram_dp
  import hack_mem_pkg::*;
#(
  parameter int WIDTH          = HACK_WORD_W,
  parameter int ADDR_W         = HACK_RAM_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clock,
  input  logic          reset,
  hack_ram_dp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_b_q;

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;

  hack_ram_clear_fsm #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clock_i    (clock),
    .reset_i    (reset),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Clear engine owns the write port while active; CPU writes are dropped.
  // Reset blocks every write, including a coincident CPU load.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.addr;
    mem_wdata = bus.in;
    if (!reset) begin
      if (clr_we) begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = '0;
      end else if (bus.load) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q   <= '0;
      addr_b_q <= '0;
    end else begin
      addr_q   <= bus.addr;
      addr_b_q <= bus.addr_b;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign bus.out   = busy ? '0 : mem_q[addr_q];
  assign bus.out_b = busy ? '0 : mem_q[addr_b_q];
  assign bus.busy  = busy;

endmodule

// File: tb/tb_hack_ram_dp.sv
// Self-checking bench for hack_ram_dp: one instance without and one with the
// reset-time clear sweep, sharing stimulus, separately reset.
module tb_hack_ram_dp;
  import hack_mem_pkg::*;

  localparam int W     = 16;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst0, rst1, sel;
  logic          load;
  logic [W-1:0]  din;
  logic [AW-1:0] addr, addr_b;

  hack_ram_dp_if #(.WIDTH(W), .ADDR_W(AW)) if0 ();
  hack_ram_dp_if #(.WIDTH(W), .ADDR_W(AW)) if1 ();

  assign if0.load   = load;
  assign if0.in     = din;
  assign if0.addr   = addr;
  assign if0.addr_b = addr_b;
  assign if1.load   = load;
  assign if1.in     = din;
  assign if1.addr   = addr;
  assign if1.addr_b = addr_b;

  hack_ram_dp #(.WIDTH(W), .ADDR_W(AW), .CLEAR_ON_RESET(0)) dut0 (
    .clock (clock), .reset (rst0), .bus (if0));
  hack_ram_dp #(.WIDTH(W), .ADDR_W(AW), .CLEAR_ON_RESET(1)) dut1 (
    .clock (clock), .reset (rst1), .bus (if1));

  wire [W-1:0] obs_out   = sel ? if1.out   : if0.out;
  wire [W-1:0] obs_out_b = sel ? if1.out_b : if0.out_b;
  wire         obs_busy  = sel ? if1.busy  : if0.busy;

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          ld;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic [AW-1:0] ab;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
  } vec_t;

  // Drive one cycle of stimulus; the expectation is queued now and retired
  // once the edge that produces the registered-address read has passed.
  task automatic step(string name, logic ld, logic [AW-1:0] a, logic [W-1:0] d,
                      logic [AW-1:0] ab, logic [W-1:0] ea, logic [W-1:0] eb);
    exp_t e;
    load   = ld;
    addr   = a;
    din    = d;
    addr_b = ab;
    e.name = name;
    e.a    = ea;
    e.b    = eb;
    sb.push_back(e);
    @(posedge clock); #1;
    load = 1'b0;
    e = sb.pop_front();
    check({e.name, " out"},   32'(obs_out),   32'(e.a));
    check({e.name, " out_b"}, 32'(obs_out_b), 32'(e.b));
    check({e.name, " busy"},  32'(obs_busy),  32'd0);
  endtask

  task automatic pulse_reset1(string name);
    rst1 = 1'b1;
    load = 1'b0;
    @(posedge clock); #1;
    rst1 = 1'b0;
    check({name, " busy at reset"}, 32'(obs_busy), 32'd1);
    check({name, " out at reset"},  32'(obs_out),  32'd0);
  endtask

  // Counts busy cycles and any non-zero read while busy. inj >= 0 drives a
  // load to 0x0010 on clear cycle inj and to 0x0001 two cycles later.
  task automatic sweep(string name, int inj);
    int n  = 0;
    int nz = 0;
    while (obs_busy === 1'b1 && n < DEPTH + 64) begin
      if (obs_out !== '0 || obs_out_b !== '0) nz++;
      load = (inj >= 0) && (n == inj || n == inj + 2);
      addr = (n == inj) ? 14'h0010 : 14'h0001;
      din  = 16'hAAAA;
      n++;
      @(posedge clock); #1;
    end
    load = 1'b0;
    check({name, " busy cycles"}, 32'(n), 32'(DEPTH));
    check({name, " out zero while busy"}, 32'(nz), 32'd0);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{1'b1, 14'h0000, 16'h0C0C, 14'h0000, 16'h0C0C, 16'h0C0C};
    vt[1] = '{1'b1, 14'h0005, 16'h1234, 14'h0005, 16'h1234, 16'h1234};
    vt[2] = '{1'b0, 14'h0005, 16'h0000, 14'h0000, 16'h1234, 16'h0C0C};
    vt[3] = '{1'b1, 14'h3FFF, 16'hBEEF, 14'h0005, 16'hBEEF, 16'h1234};
    vt[4] = '{1'b0, 14'h0000, 16'h0000, 14'h3FFF, 16'h0C0C, 16'hBEEF};
    vt[5] = '{1'b1, 14'h2000, 16'h0001, 14'h2000, 16'h0001, 16'h0001};
    vt[6] = '{1'b0, 14'h2000, 16'h0000, 14'h3FFF, 16'h0001, 16'hBEEF};
    vt[7] = '{1'b1, 14'h0007, 16'h0042, 14'h0000, 16'h0042, 16'h0C0C};

    rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
    load = 1'b0; din = '0; addr = '0; addr_b = '0;
    @(posedge clock); @(posedge clock); #1;
    rst0 = 1'b0;
    check("dut0 busy after reset", 32'(obs_busy), 32'd0);

    // Normal and dual-port traffic, no clear engine.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("vec%0d", i), vt[i].ld, vt[i].a, vt[i].d, vt[i].ab, vt[i].ea, vt[i].eb);
    end

    // Reset and load together: reset wins, memory preserved, address regs zeroed.
    rst0 = 1'b1; load = 1'b1; addr = 14'h0007; addr_b = 14'h0007; din = 16'h7777;
    @(posedge clock); #1;
    rst0 = 1'b0; load = 1'b0;
    check("rst+load out addr0",   32'(obs_out),   32'h0C0C);
    check("rst+load out_b addr0", 32'(obs_out_b), 32'h0C0C);
    check("rst+load busy",        32'(obs_busy),  32'd0);
    step("rst+load read7", 1'b0, 14'h0007, 16'h0, 14'h0007, 16'h0042, 16'h0042);

    // Clear engine instance: first sweep with loads injected mid-clear.
    sel = 1'b1;
    @(posedge clock); #1;
    rst1 = 1'b0;
    check("dut1 busy at reset", 32'(obs_busy), 32'd1);
    check("dut1 out at reset",  32'(obs_out),  32'd0);
    sweep("load-during-clear", 3);
    step("ldclr read 0010", 1'b0, 14'h0010, 16'h0, 14'h0001, 16'h0000, 16'h0000);

    // Preload and full sweep.
    step("pre 0000", 1'b1, 14'h0000, 16'hFFFF, 14'h0000, 16'hFFFF, 16'hFFFF);
    step("pre 1FFF", 1'b1, 14'h1FFF, 16'hFFFF, 14'h0000, 16'hFFFF, 16'hFFFF);
    step("pre 3FFF", 1'b1, 14'h3FFF, 16'hFFFF, 14'h1FFF, 16'hFFFF, 16'hFFFF);
    pulse_reset1("sweep");
    sweep("sweep", -1);
    step("sweep rd 0000/1FFF", 1'b0, 14'h0000, 16'h0, 14'h1FFF, 16'h0000, 16'h0000);
    step("sweep rd 3FFF",      1'b0, 14'h3FFF, 16'h0, 14'h0000, 16'h0000, 16'h0000);

    // Reset at clear cycle 100 restarts the sweep.
    step("pre 5555", 1'b1, 14'h3FFF, 16'h5555, 14'h3FFF, 16'h5555, 16'h5555);
    pulse_reset1("midclr first");
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
    end
    pulse_reset1("midclr second");
    sweep("midclr", -1);
    step("midclr rd 3FFF", 1'b0, 14'h3FFF, 16'h0, 14'h3FFF, 16'h0000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
